synchronous_fifo_counted: RTL and testbench
===========================================

Name: synchronous_fifo_counted

Overview:
Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. DEPTH is not restricted to a power of two. Keeps the push/poll/head/tail/full/empty contract of the existing synchronous FIFO, so it drops into the same datapaths. Intended for queues that need back-pressure margin and error reporting.

Parameters:
DEPTH, 4, number of entries; any integer >= 2, including non-power-of-two values.
DATA_WIDTH, 2, width of each entry in bits.
AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH; legal range is 1..DEPTH.
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH; legal range is 0..DEPTH-1.
CW, $clog2(DEPTH+1), width of the count output. Derived; do not override.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
push  in  1  request to enqueue data_in this cycle.
poll  in  1  request to dequeue the head entry this cycle.
data_in  in  DATA_WIDTH  data to enqueue.
clr_err  in  1  clears overflow and underflow.
head  out  DATA_WIDTH  oldest entry; the one poll removes.
tail  out  DATA_WIDTH  newest entry; the one most recently pushed.
count  out  CW  current occupancy, 0..DEPTH.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_THRESH.
almost_empty  out  1  count <= AE_THRESH.
overflow  out  1  sticky: a push was rejected.
underflow  out  1  sticky: a poll was rejected.

Behaviour:
- Reset (rst=1 at posedge):
  - rd_ptr = wr_ptr = 0 and count = 0.
  - overflow = underflow = 0.
  - Outputs: empty=1, full=0, almost_empty=1, almost_full=0, head=0, tail=0.
  - Storage array is not reset.
  - Reset overrides push, poll and clr_err in the same cycle.
  - Reset mid-operation discards all contents.
- Acceptance per cycle, evaluated on pre-edge state:
  - push_ok = push & (!full | poll).
  - poll_ok = poll & !empty.
- Effects of an accepted operation:
  - push_ok: mem[wr_ptr] <= data_in; wr_ptr advances.
  - poll_ok: rd_ptr advances.
  - count <= count + push_ok - poll_ok.
- Pointer wrap: a pointer equal to DEPTH-1 goes to 0; otherwise it increments by 1. Explicit compare, never modulo 2^n.
- Simultaneous push+poll:
  - Not empty: both accepted; count unchanged.
  - Full: both accepted; full stays 1. The write slot is the one freed by the poll, so the pointers stay consistent.
  - Empty: push accepted, poll rejected; count becomes 1; underflow sets.
- Error flags:
  - push & !push_ok sets overflow; data_in is dropped and no state changes.
  - poll & !empty is false -> poll & empty sets underflow.
  - Both flags hold until clr_err=1 or reset.
  - If clr_err and a new error occur in the same cycle, set wins (flag = 1).
- Outputs are combinational from registered state, zero latency:
  - head = mem[rd_ptr].
  - tail = mem[wr_ptr==0 ? DEPTH-1 : wr_ptr-1].
  - When empty=1, head and tail are forced to 0.
  - A pushed word is visible on tail, and on head if the FIFO was empty, in the cycle after the push edge.
- Flags full, empty, almost_full and almost_empty are decoded combinationally from count only.
- Inputs are assumed X-free after reset deasserts.

Test Plan:
Use DEPTH=5, DATA_WIDTH=8, AF_THRESH=4, AE_THRESH=1 unless noted.
1. Fill/drain with wrap: push 0x11,0x22,0x33,0x44,0x55 -> count=5, full=1, almost_full=1, head=0x11, tail=0x55. Then poll 3 and push 0x66,0x77 -> head=0x44, tail=0x77, count=4 after wrap past slot 4. Then drain 4 -> empty=1, head=tail=0.
2. Overflow: when full (5 entries), push 0x99 alone -> overflow=1, count=5, tail unchanged at 0x55. Next cycle clr_err=1 -> overflow=0.
3. Underflow on empty with push: empty, push=1 data 0xA5 and poll=1 -> count=1, head=tail=0xA5, underflow=1. Stays 1 for 3 idle cycles.
4. Push+poll when full: 5 entries 0x01..0x05, push 0x06 with poll -> count=5, full=1, head=0x02, tail=0x06, overflow=0.
5. Threshold edges: count 0->1 gives almost_empty=1; 1->2 gives 0; 3->4 gives almost_full=1; 4->3 gives 0.
6. Reset mid-operation: 3 entries plus overflow=1, assert rst with push=1 -> next cycle count=0, empty=1, overflow=0, head=tail=0. Then random push/poll/data_in for 10k cycles against a queue model: head, tail, count and all flags must match every cycle.

Source files
------------

// File: rtl/synchronous_fifo_counted.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and sticky error flags.
// Zero-latency outputs from registered state; a rejected push or poll sets a sticky flag and changes nothing else.
module synchronous_fifo_counted #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 2,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  poll,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] head,
    output logic [DATA_WIDTH-1:0] tail,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         tail_ptr;
    logic                  push_ok;
    logic                  poll_ok;

    // Explicit wrap compare so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    // When full, a simultaneous poll frees the slot the push writes into.
    assign push_ok = push & (~full | poll);
    assign poll_ok = poll & ~empty;

    assign tail_ptr = (wr_ptr == '0) ? LAST : wr_ptr - PW'(1);
    assign head     = empty ? '0 : mem[rd_ptr];
    assign tail     = empty ? '0 : mem[tail_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (poll_ok) rd_ptr <= next_ptr(rd_ptr);
            case ({push_ok, poll_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A new error in the same cycle as clr_err wins.
            if (push & ~push_ok)  overflow <= 1'b1;
            else if (clr_err)     overflow <= 1'b0;
            if (poll & ~poll_ok)  underflow <= 1'b1;
            else if (clr_err)     underflow <= 1'b0;
        end
    end

    // Storage carries no reset; contents are only observable while counted.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= data_in;
    end

endmodule

// File: tb/tb_synchronous_fifo_counted.sv
// Directed checks of fill/drain, wrap, thresholds, error flags and reset, then a randomised run against a queue model.
module tb_synchronous_fifo_counted;

    localparam int DEPTH = 5;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic          poll = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    int vectors = 0;
    int miscompares = 0;

    synchronous_fifo_counted #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_THRESH(4), .AE_THRESH(1)
    ) dut (
        .clk(clk), .rst(rst), .push(push), .poll(poll), .data_in(data_in),
        .clr_err(clr_err), .head(head), .tail(tail), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic pu, input logic po, input logic [DW-1:0] d, input logic ce);
        push = pu; poll = po; data_in = d; clr_err = ce;
        @(posedge clk);
        #1;
        push = 1'b0; poll = 1'b0; clr_err = 1'b0;
    endtask

    task automatic chk_all(input string tag, input int c, input logic [DW-1:0] h, input logic [DW-1:0] t,
                           input logic f, input logic e, input logic af, input logic ae,
                           input logic ov, input logic un);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".head"}, 32'(head), 32'(h));
        chk({tag, ".tail"}, 32'(tail), 32'(t));
        chk({tag, ".full"}, 32'(full), 32'(f));
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".afull"}, 32'(almost_full), 32'(af));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(ae));
        chk({tag, ".ovf"}, 32'(overflow), 32'(ov));
        chk({tag, ".unf"}, 32'(underflow), 32'(un));
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic          m_ovf;
        logic          m_unf;
        logic          pu, po, ce, pok, qok;
        logic [DW-1:0] d;
        int            p_push;

        // Reset
        rst = 1'b1;
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        chk_all("reset", 0, 8'h00, 8'h00, 0, 1, 0, 1, 0, 0);

        // Fill to full
        cyc(1, 0, 8'h11, 0);
        chk_all("fill1", 1, 8'h11, 8'h11, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 8'h22, 0);
        chk_all("fill2", 2, 8'h11, 8'h22, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 8'h33, 0);
        cyc(1, 0, 8'h44, 0);
        chk_all("fill4", 4, 8'h11, 8'h44, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 8'h55, 0);
        chk_all("fill5", 5, 8'h11, 8'h55, 1, 0, 1, 0, 0, 0);

        // Overflow when full, then clear
        cyc(1, 0, 8'h99, 0);
        chk_all("ovf_set", 5, 8'h11, 8'h55, 1, 0, 1, 0, 1, 0);
        cyc(0, 0, 8'h00, 1);
        chk_all("ovf_clr", 5, 8'h11, 8'h55, 1, 0, 1, 0, 0, 0);

        // Poll 3, push 2 across the wrap
        cyc(0, 1, 8'h00, 0);
        chk_all("poll1", 4, 8'h22, 8'h55, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 8'h00, 0);
        chk_all("poll2", 3, 8'h33, 8'h55, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 8'h00, 0);
        cyc(1, 0, 8'h66, 0);
        chk_all("wrap66", 3, 8'h44, 8'h66, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 8'h77, 0);
        chk_all("wrap77", 4, 8'h44, 8'h77, 0, 0, 1, 0, 0, 0);

        // Drain
        cyc(0, 1, 8'h00, 0);
        chk_all("drain1", 3, 8'h55, 8'h77, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 8'h00, 0);
        cyc(0, 1, 8'h00, 0);
        chk_all("drain3", 1, 8'h77, 8'h77, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 8'h00, 0);
        chk_all("drained", 0, 8'h00, 8'h00, 0, 1, 0, 1, 0, 0);

        // Push+poll on empty: push lands, underflow sets and sticks
        cyc(1, 1, 8'hA5, 0);
        chk_all("pp_empty", 1, 8'hA5, 8'hA5, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 8'h00, 0);
            chk("unf_sticky", 32'(underflow), 32'd1);
        end
        cyc(0, 0, 8'h00, 1);
        chk("unf_clr", 32'(underflow), 32'd0);

        // Clear and a new error in the same cycle: set wins
        cyc(0, 1, 8'h00, 0);
        cyc(0, 1, 8'h00, 1);
        chk_all("unf_setwins", 0, 8'h00, 8'h00, 0, 1, 0, 1, 0, 1);
        cyc(0, 0, 8'h00, 1);

        // Reset, then push+poll when full
        rst = 1'b1;
        cyc(0, 0, 8'h00, 0);
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) cyc(1, 0, 8'(i), 0);
        chk_all("full_0105", 5, 8'h01, 8'h05, 1, 0, 1, 0, 0, 0);
        cyc(1, 1, 8'h06, 0);
        chk_all("pp_full", 5, 8'h02, 8'h06, 1, 0, 1, 0, 0, 0);

        // Three entries plus overflow, then reset with push asserted
        cyc(1, 0, 8'h07, 0);
        cyc(0, 1, 8'h00, 0);
        cyc(0, 1, 8'h00, 0);
        chk_all("pre_rst", 3, 8'h04, 8'h06, 0, 0, 0, 0, 1, 0);
        rst = 1'b1;
        cyc(1, 0, 8'hEE, 1);
        rst = 1'b0;
        chk_all("mid_rst", 0, 8'h00, 8'h00, 0, 1, 0, 1, 0, 0);

        // Randomised run against a queue model
        q = {};
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            p_push = ((n / 400) % 2 == 0) ? 70 : 30;
            pu = ($urandom_range(0, 99) < p_push);
            po = ($urandom_range(0, 99) < 50);
            ce = ($urandom_range(0, 15) == 0);
            d  = 8'($urandom);
            pok = pu && ((q.size() != DEPTH) || po);
            qok = po && (q.size() != 0);
            m_ovf = (pu && !pok) ? 1'b1 : (ce ? 1'b0 : m_ovf);
            m_unf = (po && !qok) ? 1'b1 : (ce ? 1'b0 : m_unf);
            if (qok) void'(q.pop_front());
            if (pok) q.push_back(d);
            cyc(pu, po, d, ce);
            chk_all("rand", q.size(),
                    (q.size() != 0) ? q[0] : 8'h00,
                    (q.size() != 0) ? q[$] : 8'h00,
                    q.size() == DEPTH, q.size() == 0,
                    q.size() >= 4, q.size() <= 1, m_ovf, m_unf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
